// File: rtl/mips31_pkg.sv
// mips31_pkg
//   Shared constants for the MIPS-subset decode stage:
//     - width of the one-hot instruction_type vector
//     - opcode (code[31:26]) and funct (code[5:0]) values
//     - bit index of each instruction in the instruction_type vector
//     - decode-stage occupancy state type
//     - helper that builds a one-hot type vector from a bit index
package mips31_pkg;

    localparam int TYPE_W = 32;

    // Opcodes, code[31:26]
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    // Funct values for OP_SPECIAL, code[5:0]
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // Bit positions inside instruction_type; bit 31 is never set
    localparam int T_ADD   = 0;
    localparam int T_ADDU  = 1;
    localparam int T_SUB   = 2;
    localparam int T_SUBU  = 3;
    localparam int T_AND   = 4;
    localparam int T_OR    = 5;
    localparam int T_XOR   = 6;
    localparam int T_NOR   = 7;
    localparam int T_SLT   = 8;
    localparam int T_SLTU  = 9;
    localparam int T_SLL   = 10;
    localparam int T_SRL   = 11;
    localparam int T_SRA   = 12;
    localparam int T_SLLV  = 13;
    localparam int T_SRLV  = 14;
    localparam int T_SRAV  = 15;
    localparam int T_JR    = 16;
    localparam int T_ADDI  = 17;
    localparam int T_ADDIU = 18;
    localparam int T_ANDI  = 19;
    localparam int T_ORI   = 20;
    localparam int T_XORI  = 21;
    localparam int T_LUI   = 22;
    localparam int T_LW    = 23;
    localparam int T_SW    = 24;
    localparam int T_BEQ   = 25;
    localparam int T_BNE   = 26;
    localparam int T_SLTI  = 27;
    localparam int T_SLTIU = 28;
    localparam int T_J     = 29;
    localparam int T_JAL   = 30;

    // Number of words held by the decode stage
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } occ_state_e;

    function automatic logic [TYPE_W-1:0] type_bit(input int idx);
        logic [TYPE_W-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mips31_type_decoder.sv
// mips31_type_decoder
//   Purely combinational decode of one instruction word into a one-hot
//   instruction_type vector. Only opcode (code[31:26]) and funct
//   (code[5:0]) are inspected; everything else is ignored.
// Ports:
//   i_code    [31:0]      raw instruction word
//   o_type    [TYPE_W-1:0] one-hot type, all zero for an unsupported word
//   o_illegal             1 when the word matches no supported instruction
module mips31_type_decoder
    import mips31_pkg::*;
(
    input  logic [31:0]       i_code,
    output logic [TYPE_W-1:0] o_type,
    output logic              o_illegal
);

    logic [5:0] w_op;
    logic [5:0] w_fn;

    assign w_op = i_code[31:26];
    assign w_fn = i_code[5:0];

    always_comb begin
        o_type = '0;
        case (w_op)
            OP_SPECIAL: begin
                case (w_fn)
                    FN_ADD:  o_type = type_bit(T_ADD);
                    FN_ADDU: o_type = type_bit(T_ADDU);
                    FN_SUB:  o_type = type_bit(T_SUB);
                    FN_SUBU: o_type = type_bit(T_SUBU);
                    FN_AND:  o_type = type_bit(T_AND);
                    FN_OR:   o_type = type_bit(T_OR);
                    FN_XOR:  o_type = type_bit(T_XOR);
                    FN_NOR:  o_type = type_bit(T_NOR);
                    FN_SLT:  o_type = type_bit(T_SLT);
                    FN_SLTU: o_type = type_bit(T_SLTU);
                    FN_SLL:  o_type = type_bit(T_SLL);
                    FN_SRL:  o_type = type_bit(T_SRL);
                    FN_SRA:  o_type = type_bit(T_SRA);
                    FN_SLLV: o_type = type_bit(T_SLLV);
                    FN_SRLV: o_type = type_bit(T_SRLV);
                    FN_SRAV: o_type = type_bit(T_SRAV);
                    FN_JR:   o_type = type_bit(T_JR);
                    default: o_type = '0;
                endcase
            end
            OP_ADDI:  o_type = type_bit(T_ADDI);
            OP_ADDIU: o_type = type_bit(T_ADDIU);
            OP_ANDI:  o_type = type_bit(T_ANDI);
            OP_ORI:   o_type = type_bit(T_ORI);
            OP_XORI:  o_type = type_bit(T_XORI);
            OP_LUI:   o_type = type_bit(T_LUI);
            OP_LW:    o_type = type_bit(T_LW);
            OP_SW:    o_type = type_bit(T_SW);
            OP_BEQ:   o_type = type_bit(T_BEQ);
            OP_BNE:   o_type = type_bit(T_BNE);
            OP_SLTI:  o_type = type_bit(T_SLTI);
            OP_SLTIU: o_type = type_bit(T_SLTIU);
            OP_J:     o_type = type_bit(T_J);
            OP_JAL:   o_type = type_bit(T_JAL);
            default:  o_type = '0;
        endcase
    end

    // Every supported word sets exactly one bit, so "no bit" means illegal.
    assign o_illegal = (o_type == '0);

endmodule

// File: rtl/instruction_decode_stage.sv
// instruction_decode_stage
//   Registered decode stage between instruction memory and the
//   micro-operation producer. Words are decoded on entry, so the type is
//   registered together with the code (1-cycle latency). A 2-entry skid
//   buffer (main + skid) lets in_ready be a registered signal.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_code  upstream word and its valid
//   in_ready          registered: stage can accept a word this cycle
//   flush             drop every held and incoming word this cycle
//   out_ready         downstream consumes the output this cycle
//   out_valid         instruction_code/instruction_type/illegal are valid
//   instruction_code  held word
//   instruction_type  one-hot decode of the held word
//   illegal           held word is unsupported
//   decoded_cnt       words delivered downstream (wraps)
//   illegal_cnt       illegal words delivered downstream (wraps)
module instruction_decode_stage #(
    parameter int TYPE_W = mips31_pkg::TYPE_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [31:0]       in_code,
    output logic              in_ready,
    input  logic              flush,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [31:0]       instruction_code,
    output logic [TYPE_W-1:0] instruction_type,
    output logic              illegal,
    output logic [CNT_W-1:0]  decoded_cnt,
    output logic [CNT_W-1:0]  illegal_cnt
);
    import mips31_pkg::*;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    occ_state_e r_state;
    occ_state_e w_state_nxt;
    logic       r_out_valid;
    logic       r_in_ready;

    logic [31:0]       r_code_p1;
    logic [TYPE_W-1:0] r_type_p1;
    logic              r_illegal_p1;
    logic [31:0]       r_skid_code_p1;
    logic [TYPE_W-1:0] r_skid_type_p1;
    logic              r_skid_illegal_p1;

    logic [CNT_W-1:0]  r_decoded_cnt;
    logic [CNT_W-1:0]  r_illegal_cnt;

    logic [TYPE_W-1:0] w_dec_type_p0;
    logic              w_dec_illegal_p0;
    logic              w_accept;
    logic              w_deliver;
    logic              w_load_main;
    logic              w_main_from_skid;
    logic              w_load_skid;
    logic              w_clear;

    // ---- stage p0: combinational decode of the incoming word ----
    mips31_type_decoder u_decoder (
        .i_code    (in_code),
        .o_type    (w_dec_type_p0),
        .o_illegal (w_dec_illegal_p0)
    );

    assign w_accept  = in_valid & r_in_ready;
    assign w_deliver = r_out_valid & out_ready;

    // Occupancy FSM. Accept can only happen while in_ready=1, which the
    // FULL state never has, so FULL only reacts to a deliver.
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main      = 1'b0;
        w_main_from_skid = 1'b0;
        w_load_skid      = 1'b0;
        w_clear          = 1'b0;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
            w_clear     = 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_load_main = 1'b1;
                        w_state_nxt = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_deliver && w_accept) begin
                        w_load_main = 1'b1;
                    end else if (w_deliver) begin
                        w_state_nxt = ST_EMPTY;
                    end else if (w_accept) begin
                        w_load_skid = 1'b1;
                        w_state_nxt = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (w_deliver) begin
                        w_main_from_skid = 1'b1;
                        w_state_nxt      = ST_ONE;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    // out_valid and in_ready are registered copies of the next occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= (w_state_nxt != ST_EMPTY);
            r_in_ready  <= (w_state_nxt != ST_FULL);
        end
    end

    // ---- stage p1: main (output) and skid registers ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_code_p1         <= '0;
            r_type_p1         <= '0;
            r_illegal_p1      <= 1'b0;
            r_skid_code_p1    <= '0;
            r_skid_type_p1    <= '0;
            r_skid_illegal_p1 <= 1'b0;
        end else begin
            if (w_clear) begin
                r_code_p1    <= '0;
                r_type_p1    <= '0;
                r_illegal_p1 <= 1'b0;
            end else if (w_load_main) begin
                r_code_p1    <= in_code;
                r_type_p1    <= w_dec_type_p0;
                r_illegal_p1 <= w_dec_illegal_p0;
            end else if (w_main_from_skid) begin
                r_code_p1    <= r_skid_code_p1;
                r_type_p1    <= r_skid_type_p1;
                r_illegal_p1 <= r_skid_illegal_p1;
            end
            if (w_load_skid) begin
                r_skid_code_p1    <= in_code;
                r_skid_type_p1    <= w_dec_type_p0;
                r_skid_illegal_p1 <= w_dec_illegal_p0;
            end
        end
    end

    // A deliver in a flush cycle was really consumed downstream, so it counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_decoded_cnt <= '0;
            r_illegal_cnt <= '0;
        end else if (w_deliver) begin
            r_decoded_cnt <= r_decoded_cnt + CNT_ONE;
            if (r_illegal_p1) begin
                r_illegal_cnt <= r_illegal_cnt + CNT_ONE;
            end
        end
    end

    assign in_ready         = r_in_ready;
    assign out_valid        = r_out_valid;
    assign instruction_code = r_code_p1;
    assign instruction_type = r_type_p1;
    assign illegal          = r_illegal_p1;
    assign decoded_cnt      = r_decoded_cnt;
    assign illegal_cnt      = r_illegal_cnt;

endmodule

// File: tb/tb_instruction_decode_stage.sv
module tb_instruction_decode_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_code;
    logic        flush;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [31:0] instruction_code;
    logic [31:0] instruction_type;
    logic        illegal;
    logic [15:0] decoded_cnt;
    logic [15:0] illegal_cnt;

    logic        in_ready_4;
    logic        out_valid_4;
    logic [31:0] instruction_code_4;
    logic [31:0] instruction_type_4;
    logic        illegal_4;
    logic [3:0]  decoded_cnt_4;
    logic [3:0]  illegal_cnt_4;

    int total = 0;
    int bad   = 0;

    instruction_decode_stage u_dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_code          (in_code),
        .in_ready         (in_ready),
        .flush            (flush),
        .out_ready        (out_ready),
        .out_valid        (out_valid),
        .instruction_code (instruction_code),
        .instruction_type (instruction_type),
        .illegal          (illegal),
        .decoded_cnt      (decoded_cnt),
        .illegal_cnt      (illegal_cnt)
    );

    // Same stimulus, 4-bit counters, used for the wrap check.
    instruction_decode_stage #(.CNT_W(4)) u_dut4 (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_code          (in_code),
        .in_ready         (in_ready_4),
        .flush            (flush),
        .out_ready        (out_ready),
        .out_valid        (out_valid_4),
        .instruction_code (instruction_code_4),
        .instruction_type (instruction_type_4),
        .illegal          (illegal_4),
        .decoded_cnt      (decoded_cnt_4),
        .illegal_cnt      (illegal_cnt_4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [31:0] v_code [9] = '{32'h014B4820, 32'h8C880004, 32'h0C000010, 32'h00000000,
                                32'hFC000000, 32'h00000022, 32'h00000008, 32'h10000000,
                                32'h00000001};
    logic [31:0] v_type [9] = '{32'h00000001, 32'h00800000, 32'h40000000, 32'h00000400,
                                32'h00000000, 32'h00000004, 32'h00010000, 32'h02000000,
                                32'h00000000};
    logic        v_ill  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_code   = 32'h0;
        flush     = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_illegal",   32'(illegal),   32'd0);
        chk("rst_code",      instruction_code, 32'h0);
        chk("rst_type",      instruction_type, 32'h0);
        chk("rst_dec_cnt",   32'(decoded_cnt), 32'd0);
        chk("rst_ill_cnt",   32'(illegal_cnt), 32'd0);

        // Streaming decode, one word per cycle, downstream always ready
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            in_code  = v_code[i];
            tick();
            chk($sformatf("dec%0d_valid", i),   32'(out_valid), 32'd1);
            chk($sformatf("dec%0d_code", i),    instruction_code, v_code[i]);
            chk($sformatf("dec%0d_type", i),    instruction_type, v_type[i]);
            chk($sformatf("dec%0d_illegal", i), 32'(illegal), 32'(v_ill[i]));
            chk($sformatf("dec%0d_cnt", i),     32'(decoded_cnt), i);
        end
        chk("ill_cnt_before_last", 32'(illegal_cnt), 32'd1);
        in_valid = 1'b0;
        tick();
        chk("stream_out_valid", 32'(out_valid), 32'd0);
        chk("stream_dec_cnt",   32'(decoded_cnt), 32'd9);
        chk("stream_ill_cnt",   32'(illegal_cnt), 32'd2);

        // Backpressure: three words pushed, only two fit
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = 32'h00000021;
        tick();
        chk("bp_w1_in_ready", 32'(in_ready), 32'd1);
        chk("bp_w1_code",     instruction_code, 32'h00000021);
        in_code = 32'h3C010000;
        tick();
        chk("bp_full_in_ready", 32'(in_ready), 32'd0);
        chk("bp_full_code",     instruction_code, 32'h00000021);
        in_code = 32'h08000000;
        tick();
        chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
        chk("bp_hold_valid",    32'(out_valid), 32'd1);
        chk("bp_hold_code",     instruction_code, 32'h00000021);
        chk("bp_hold_type",     instruction_type, 32'h00000002);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_w2_code",     instruction_code, 32'h3C010000);
        chk("bp_w2_type",     instruction_type, 32'h00400000);
        chk("bp_w2_in_ready", 32'(in_ready), 32'd1);
        chk("bp_w2_valid",    32'(out_valid), 32'd1);
        tick();
        chk("bp_drain_valid", 32'(out_valid), 32'd0);
        chk("bp_dec_cnt",     32'(decoded_cnt), 32'd11);

        // Flush while full, with a concurrent incoming word
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = 32'h00000023;
        tick();
        in_code = 32'h2C000000;
        tick();
        chk("fl_pre_in_ready", 32'(in_ready), 32'd0);
        flush   = 1'b1;
        in_code = 32'h08000000;
        tick();
        chk("fl_out_valid", 32'(out_valid), 32'd0);
        chk("fl_in_ready",  32'(in_ready),  32'd1);
        chk("fl_dec_cnt",   32'(decoded_cnt), 32'd11);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("fl_after_valid", 32'(out_valid), 32'd0);
        chk("fl_after_cnt",   32'(decoded_cnt), 32'd11);
        chk("fl_after_ill",   32'(illegal_cnt), 32'd2);

        // Reset while full and stalled
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = 32'hFC000000;
        tick();
        chk("mr_pre_illegal", 32'(illegal), 32'd1);
        in_code = 32'h00000020;
        tick();
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_out_valid", 32'(out_valid), 32'd0);
        chk("mr_in_ready",  32'(in_ready),  32'd1);
        chk("mr_code",      instruction_code, 32'h0);
        chk("mr_type",      instruction_type, 32'h0);
        chk("mr_illegal",   32'(illegal), 32'd0);
        chk("mr_dec_cnt",   32'(decoded_cnt), 32'd0);
        chk("mr_ill_cnt",   32'(illegal_cnt), 32'd0);

        // Counter wrap: 17 words with op=0, fn=0..16 (10 of them illegal)
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1;
            in_code  = 32'(i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("wrap_dec_cnt4",  32'(decoded_cnt_4), 32'd1);
        chk("wrap_ill_cnt4",  32'(illegal_cnt_4), 32'd10);
        chk("wrap_dec_cnt16", 32'(decoded_cnt),   32'd17);
        chk("wrap_ill_cnt16", 32'(illegal_cnt),   32'd10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
